fiber_evt_arbiter: RTL and testbench

Parametrised event-block forwarder for the fiber link.
- Moves complete event blocks from NCH event-builder output FIFOs (first-word-fall-through) into the fiber event FIFO.
- Channels are arbitrated round-robin, one whole block at a time.
- Each block ends when its block trailer is copied, followed by one end-marker write.
- Adds an over-long block guard, a block counter and error reporting.

---
 rtl/fiber_evt_arbiter.sv | 151 +++++++++++++++
 tb/tb_fiber_evt_arbiter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fiber_evt_arbiter.sv
// Round-robin forwarder of whole event blocks from NCH FWFT FIFOs into the fiber
// event FIFO; each block closes with its trailer word followed by one end marker.
module fiber_evt_arbiter #(
  parameter int unsigned   NCH       = 2,
  parameter int unsigned   DW        = 32,
  parameter logic [DW-1:0] TRL_MASK  = 32'h00F00000,
  parameter logic [DW-1:0] TRL_VAL   = 32'h00100000,
  parameter int unsigned   MAX_WORDS = 4096
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ENABLE,
  input  logic [NCH-1:0]    IN_EMPTY,
  output logic [NCH-1:0]    IN_RD,
  input  logic [NCH*DW-1:0] IN_DATA,
  input  logic              OUT_FULL,
  output logic              OUT_WR,
  output logic [DW-1:0]     OUT_DATA,
  output logic              OUT_END,
  output logic [2:0]        ACTIVE_CH,
  output logic [15:0]       BLOCK_CNT,
  output logic              OVERLONG_ERR,
  input  logic              ERR_CLR
);

  localparam int unsigned   CW     = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0] MaxCnt = CW'(MAX_WORDS);

  typedef enum logic [1:0] {StIdle, StXfer, StEndw} state_e;

  state_e        state_q, state_d;
  logic [2:0]    sel_q, sel_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   blk_q, blk_d;
  logic          err_q, err_d;

  logic [DW-1:0] head;
  logic          head_empty;
  logic          is_trl;
  logic          xfer;
  logic [CW-1:0] cnt_inc;
  logic [2:0]    pick;
  logic          pick_found;

  // Head word and empty flag of the selected channel.
  always_comb begin
    head       = '0;
    head_empty = 1'b1;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (sel_q == 3'(k)) begin
        head       = IN_DATA[k*DW +: DW];
        head_empty = IN_EMPTY[k];
      end
    end
  end

  // First non-empty channel at offset 0, 1, ... from the round-robin pointer.
  always_comb begin
    pick       = ptr_q;
    pick_found = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        if (!pick_found && ((32'(ptr_q) + i) % NCH == k) && !IN_EMPTY[k]) begin
          pick_found = 1'b1;
          pick       = 3'(k);
        end
      end
    end
  end

  assign is_trl  = (head & TRL_MASK) == TRL_VAL;
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    blk_d    = blk_q;
    err_d    = err_q & ~ERR_CLR;
    xfer     = 1'b0;
    OUT_WR   = 1'b0;
    OUT_DATA = '0;
    OUT_END  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ENABLE && pick_found) begin
          sel_d   = pick;
          cnt_d   = '0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        xfer = !head_empty && !OUT_FULL;
        if (xfer) begin
          OUT_WR   = 1'b1;
          OUT_DATA = head;
          cnt_d    = cnt_inc;
          if (is_trl) begin
            state_d = StEndw;
          end else if (cnt_inc == MaxCnt) begin
            // A new overflow overrides a same-cycle clear.
            err_d   = 1'b1;
            state_d = StEndw;
          end
        end
      end
      StEndw: begin
        OUT_END = 1'b1;
        OUT_WR  = !OUT_FULL;
        if (!OUT_FULL) begin
          blk_d   = blk_q + 16'd1;
          ptr_d   = (sel_q == 3'(NCH - 1)) ? 3'd0 : sel_q + 3'd1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    IN_RD = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (xfer && (sel_q == 3'(k))) IN_RD[k] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      blk_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      err_q   <= err_d;
    end
  end

  assign ACTIVE_CH    = sel_q;
  assign BLOCK_CNT    = blk_q;
  assign OVERLONG_ERR = err_q;

endmodule

// File: tb/tb_fiber_evt_arbiter.sv
// Directed bench for fiber_evt_arbiter: FWFT FIFO models feed two channels, a
// negedge monitor captures every fiber write, and each task checks its scenario.
module tb_fiber_evt_arbiter;
  localparam int NCH = 2;
  localparam int DW  = 32;

  logic              CLK = 1'b0;
  logic              RST;
  logic              ENABLE;
  logic [NCH-1:0]    IN_EMPTY;
  logic [NCH-1:0]    IN_RD;
  logic [NCH*DW-1:0] IN_DATA;
  logic              OUT_FULL;
  logic              OUT_WR;
  logic [DW-1:0]     OUT_DATA;
  logic              OUT_END;
  logic [2:0]        ACTIVE_CH;
  logic [15:0]       BLOCK_CNT;
  logic              OVERLONG_ERR;
  logic              ERR_CLR;

  always #5 CLK = ~CLK;

  fiber_evt_arbiter #(
    .NCH      (NCH),
    .DW       (DW),
    .TRL_MASK (32'h00F00000),
    .TRL_VAL  (32'h00100000),
    .MAX_WORDS(8)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ENABLE      (ENABLE),
    .IN_EMPTY    (IN_EMPTY),
    .IN_RD       (IN_RD),
    .IN_DATA     (IN_DATA),
    .OUT_FULL    (OUT_FULL),
    .OUT_WR      (OUT_WR),
    .OUT_DATA    (OUT_DATA),
    .OUT_END     (OUT_END),
    .ACTIVE_CH   (ACTIVE_CH),
    .BLOCK_CNT   (BLOCK_CNT),
    .OVERLONG_ERR(OVERLONG_ERR),
    .ERR_CLR     (ERR_CLR)
  );

  // FWFT FIFO models
  logic [31:0] mem   [2][256];
  logic [7:0]  wr_p  [2];
  logic [7:0]  rd_p  [2];
  int          pop_cnt [2];
  logic        flush;
  int          cyc;

  initial begin
    wr_p[0] = '0; wr_p[1] = '0;
    rd_p[0] = '0; rd_p[1] = '0;
    pop_cnt[0] = 0; pop_cnt[1] = 0;
    cyc = 0;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_fifo
    assign IN_DATA[g*DW +: DW] = mem[g][rd_p[g]];
    assign IN_EMPTY[g]         = (rd_p[g] == wr_p[g]);
  end

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    for (int k = 0; k < NCH; k++) begin
      if (flush) begin
        rd_p[k] <= wr_p[k];
      end else if (IN_RD[k]) begin
        rd_p[k]    <= rd_p[k] + 8'd1;
        pop_cnt[k] <= pop_cnt[k] + 1;
      end
    end
  end

  // Write capture and protocol monitor
  logic [31:0] cap_data [$];
  logic        cap_end  [$];
  logic [2:0]  cap_ch   [$];
  int          cap_cyc  [$];
  int          viol = 0;

  always @(negedge CLK) begin
    if (OUT_WR) begin
      cap_data.push_back(OUT_DATA);
      cap_end.push_back(OUT_END);
      cap_ch.push_back(ACTIVE_CH);
      cap_cyc.push_back(cyc);
    end
    viol <= viol + ((OUT_WR && OUT_FULL) ? 1 : 0) + ((|(IN_RD & IN_EMPTY)) ? 1 : 0)
                 + ((!OUT_WR && OUT_DATA != 32'h0) ? 1 : 0);
  end

  int checks = 0;
  int errors = 0;

  task automatic push(input logic ch, input logic [31:0] w);
    mem[ch][wr_p[ch]] = w;
    wr_p[ch] = wr_p[ch] + 8'd1;
  endtask

  task automatic do_reset();
    ENABLE   = 1'b0;
    OUT_FULL = 1'b0;
    ERR_CLR  = 1'b0;
    RST      = 1'b1;
    flush    = 1'b1;
    repeat (2) begin @(posedge CLK); #1; end
    RST   = 1'b0;
    flush = 1'b0;
  endtask

  task automatic wait_wr(input int n);
    int t = 0;
    while (cap_data.size() < n && t < 300) begin @(posedge CLK); #1; t++; end
    checks++;
    if (cap_data.size() < n) begin
      errors++;
      $display("FAIL wait_wr writes %0d required %0d", cap_data.size(), n);
    end
  endtask

  task automatic wait_blk(input logic [15:0] n);
    int t = 0;
    while (BLOCK_CNT != n && t < 300) begin @(posedge CLK); #1; t++; end
    checks++;
    if (BLOCK_CNT !== n) begin
      errors++;
      $display("FAIL wait_blk BLOCK_CNT %0d required %0d", BLOCK_CNT, n);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; ENABLE = 1'b0; OUT_FULL = 1'b0; ERR_CLR = 1'b0; flush = 1'b1;
    repeat (3) begin @(posedge CLK); #1; end
    RST = 1'b0; flush = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (IN_RD !== 2'b00 || OUT_WR !== 1'b0 || OUT_END !== 1'b0 || OUT_DATA !== 32'h0) begin
      errors++;
      $display("FAIL reset_strobes got rd=%b wr=%b end=%b data=%h required 00/0/0/0",
               IN_RD, OUT_WR, OUT_END, OUT_DATA);
    end
    checks++;
    if (ACTIVE_CH !== 3'd0 || BLOCK_CNT !== 16'd0 || OVERLONG_ERR !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs got ch=%0d blk=%0d err=%b required 0/0/0",
               ACTIVE_CH, BLOCK_CNT, OVERLONG_ERR);
    end
  endtask

  task automatic test_single_block();
    logic [31:0] exp_d [5] = '{32'h1, 32'h2, 32'h3, 32'h00100003, 32'h0};
    logic        exp_e [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int b, p0;
    do_reset();
    b  = cap_data.size();
    p0 = pop_cnt[0];
    for (int i = 0; i < 4; i++) push(1'b0, exp_d[i]);
    ENABLE = 1'b1;
    wait_blk(16'd1);
    checks++;
    if (cap_data.size() - b !== 5) begin
      errors++;
      $display("FAIL single_len got %0d required 5", cap_data.size() - b);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cap_data[b+i] !== exp_d[i] || cap_end[b+i] !== exp_e[i] || cap_ch[b+i] !== 3'd0) begin
        errors++;
        $display("FAIL single_w%0d got %h/%b/%0d required %h/%b/0", i, cap_data[b+i],
                 cap_end[b+i], cap_ch[b+i], exp_d[i], exp_e[i]);
      end
    end
    checks++;
    if (cap_cyc[b+3] - cap_cyc[b] !== 3 || cap_cyc[b+4] - cap_cyc[b+3] !== 1) begin
      errors++;
      $display("FAIL single_timing got spans %0d,%0d required 3,1",
               cap_cyc[b+3] - cap_cyc[b], cap_cyc[b+4] - cap_cyc[b+3]);
    end
    checks++;
    if (pop_cnt[0] - p0 !== 4) begin
      errors++;
      $display("FAIL single_pops got %0d required 4", pop_cnt[0] - p0);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_d [12] = '{32'h0a01, 32'h00100a02, 32'h0, 32'h0b01, 32'h00100b02, 32'h0,
                                32'h0a03, 32'h00100a04, 32'h0, 32'h0b03, 32'h00100b04, 32'h0};
    logic [2:0]  exp_c [12] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1,
                                3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1};
    int b;
    do_reset();
    b = cap_data.size();
    push(1'b0, 32'h0a01); push(1'b0, 32'h00100a02); push(1'b0, 32'h0a03); push(1'b0, 32'h00100a04);
    push(1'b1, 32'h0b01); push(1'b1, 32'h00100b02); push(1'b1, 32'h0b03); push(1'b1, 32'h00100b04);
    ENABLE = 1'b1;
    wait_blk(16'd4);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (cap_data[b+i] !== exp_d[i] || cap_end[b+i] !== (exp_d[i] == 32'h0) ||
          cap_ch[b+i] !== exp_c[i]) begin
        errors++;
        $display("FAIL rr_w%0d got %h/%b/%0d required %h/%b/%0d", i, cap_data[b+i], cap_end[b+i],
                 cap_ch[b+i], exp_d[i], exp_d[i] == 32'h0, exp_c[i]);
      end
    end
    checks++;
    if (BLOCK_CNT !== 16'd4) begin
      errors++;
      $display("FAIL rr_blkcnt got %0d required 4", BLOCK_CNT);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_d [7] = '{32'h0c01, 32'h0c02, 32'h0c03, 32'h0c04, 32'h0c05, 32'h00100c06,
                               32'h0};
    int b, p0, v0;
    do_reset();
    b  = cap_data.size();
    p0 = pop_cnt[0];
    v0 = viol;
    for (int i = 0; i < 6; i++) push(1'b0, exp_d[i]);
    ENABLE = 1'b1;
    wait_wr(b + 2);
    OUT_FULL = 1'b1;
    repeat (5) @(posedge CLK);
    #1 OUT_FULL = 1'b0;
    wait_wr(b + 6);
    OUT_FULL = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    checks++;
    if (cap_data.size() - b !== 6 || OUT_END !== 1'b1) begin
      errors++;
      $display("FAIL bp_endw_hold got writes %0d end %b required 6/1", cap_data.size() - b,
               OUT_END);
    end
    OUT_FULL = 1'b0;
    wait_blk(16'd1);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (cap_data[b+i] !== exp_d[i] || cap_end[b+i] !== (i == 6)) begin
        errors++;
        $display("FAIL bp_w%0d got %h/%b required %h/%b", i, cap_data[b+i], cap_end[b+i],
                 exp_d[i], i == 6);
      end
    end
    checks++;
    if (cap_cyc[b+2] - cap_cyc[b+1] !== 6 || cap_cyc[b+6] - cap_cyc[b+5] !== 6) begin
      errors++;
      $display("FAIL bp_stall got gaps %0d,%0d required 6,6", cap_cyc[b+2] - cap_cyc[b+1],
               cap_cyc[b+6] - cap_cyc[b+5]);
    end
    checks++;
    if (pop_cnt[0] - p0 !== 6 || viol - v0 !== 0) begin
      errors++;
      $display("FAIL bp_pops got pops %0d viol %0d required 6/0", pop_cnt[0] - p0, viol - v0);
    end
  endtask

  task automatic test_starvation();
    logic [31:0] exp_d [8] = '{32'h0d01, 32'h0d02, 32'h0d03, 32'h00100d04, 32'h0,
                               32'h0e01, 32'h00100e02, 32'h0};
    logic [2:0]  exp_c [8] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1};
    int b, p1;
    do_reset();
    b  = cap_data.size();
    p1 = pop_cnt[1];
    push(1'b0, 32'h0d01); push(1'b0, 32'h0d02);
    push(1'b1, 32'h0e01); push(1'b1, 32'h00100e02);
    ENABLE = 1'b1;
    wait_wr(b + 2);
    repeat (10) @(posedge CLK);
    #1;
    checks++;
    if (cap_data.size() - b !== 2 || ACTIVE_CH !== 3'd0 || pop_cnt[1] - p1 !== 0) begin
      errors++;
      $display("FAIL starve_hold got writes %0d ch %0d ch1pops %0d required 2/0/0",
               cap_data.size() - b, ACTIVE_CH, pop_cnt[1] - p1);
    end
    push(1'b0, 32'h0d03); push(1'b0, 32'h00100d04);
    wait_blk(16'd2);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap_data[b+i] !== exp_d[i] || cap_ch[b+i] !== exp_c[i]) begin
        errors++;
        $display("FAIL starve_w%0d got %h/%0d required %h/%0d", i, cap_data[b+i], cap_ch[b+i],
                 exp_d[i], exp_c[i]);
      end
    end
    checks++;
    if (cap_cyc[b+2] - cap_cyc[b+1] !== 11) begin
      errors++;
      $display("FAIL starve_resume got gap %0d required 11", cap_cyc[b+2] - cap_cyc[b+1]);
    end
  endtask

  task automatic test_overlong();
    int b;
    do_reset();
    b = cap_data.size();
    for (int i = 0; i < 12; i++) push(1'b0, 32'h0f00 + 32'(i));
    push(1'b1, 32'h00100f80);
    ENABLE = 1'b1;
    wait_blk(16'd2);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap_data[b+i] !== 32'h0f00 + 32'(i) || cap_end[b+i] !== 1'b0) begin
        errors++;
        $display("FAIL ovl_w%0d got %h/%b required %h/0", i, cap_data[b+i], cap_end[b+i],
                 32'h0f00 + 32'(i));
      end
    end
    checks++;
    if (cap_end[b+8] !== 1'b1 || cap_data[b+8] !== 32'h0 || cap_ch[b+8] !== 3'd0) begin
      errors++;
      $display("FAIL ovl_end got %h/%b/%0d required 0/1/0", cap_data[b+8], cap_end[b+8],
               cap_ch[b+8]);
    end
    checks++;
    if (cap_data[b+9] !== 32'h00100f80 || cap_ch[b+9] !== 3'd1 || cap_end[b+10] !== 1'b1) begin
      errors++;
      $display("FAIL ovl_next got %h/ch%0d/end%b required 00100f80/ch1/end1", cap_data[b+9],
               cap_ch[b+9], cap_end[b+10]);
    end
    checks++;
    if (OVERLONG_ERR !== 1'b1) begin
      errors++;
      $display("FAIL ovl_err got %b required 1", OVERLONG_ERR);
    end
  endtask

  task automatic test_trailer_at_max();
    int b;
    do_reset();
    b = cap_data.size();
    for (int i = 0; i < 7; i++) push(1'b0, 32'h1100 + 32'(i));
    push(1'b0, 32'h00101107);
    ENABLE = 1'b1;
    wait_blk(16'd1);
    checks++;
    if (cap_data.size() - b !== 9 || cap_data[b+7] !== 32'h00101107 || cap_end[b+8] !== 1'b1 ||
        OVERLONG_ERR !== 1'b0) begin
      errors++;
      $display("FAIL trl_at_max got n=%0d last=%h end=%b err=%b required 9/00101107/1/0",
               cap_data.size() - b, cap_data[b+7], cap_end[b+8], OVERLONG_ERR);
    end
  endtask

  task automatic test_err_clear_and_reset();
    int b, t;
    do_reset();
    b = cap_data.size();
    for (int i = 0; i < 8; i++) push(1'b0, 32'h2200 + 32'(i));
    ENABLE = 1'b1;
    wait_blk(16'd1);
    checks++;
    if (OVERLONG_ERR !== 1'b1) begin
      errors++;
      $display("FAIL clr_pre got %b required 1", OVERLONG_ERR);
    end
    ERR_CLR = 1'b1;
    @(posedge CLK); #1;
    ERR_CLR = 1'b0;
    checks++;
    if (OVERLONG_ERR !== 1'b0) begin
      errors++;
      $display("FAIL clr_clear got %b required 0", OVERLONG_ERR);
    end
    for (int i = 0; i < 7; i++) push(1'b0, 32'h2300 + 32'(i));
    wait_wr(b + 16);
    ERR_CLR = 1'b1;
    push(1'b0, 32'h2307);
    t = 0;
    while (OVERLONG_ERR !== 1'b1 && t < 5) begin @(posedge CLK); #1; t++; end
    ERR_CLR = 1'b0;
    checks++;
    if (OVERLONG_ERR !== 1'b1) begin
      errors++;
      $display("FAIL clr_set_wins got %b required 1", OVERLONG_ERR);
    end
    wait_blk(16'd2);
    for (int i = 0; i < 3; i++) push(1'b0, 32'h2400 + 32'(i));
    wait_wr(b + 20);
    RST = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (IN_RD !== 2'b00 || OUT_WR !== 1'b0 || OUT_END !== 1'b0 || ACTIVE_CH !== 3'd0 ||
        BLOCK_CNT !== 16'd0 || OVERLONG_ERR !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got rd=%b wr=%b end=%b ch=%0d blk=%0d err=%b required 00/0/0/0/0/0",
               IN_RD, OUT_WR, OUT_END, ACTIVE_CH, BLOCK_CNT, OVERLONG_ERR);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_round_robin();
    test_backpressure();
    test_starvation();
    test_overlong();
    test_trailer_at_max();
    test_err_clear_and_reset();
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL protocol got %0d violations required 0", viol);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
